// File: rtl/nyq_pkg.sv
// Shared definitions for the decimating Nyquist FIR: address-map offsets,
// FSM state encoding and accumulator sizing.
package nyq_pkg;

  // Coefficients sit at OFS_COEFF..; the control words sit right after the taps.
  localparam int unsigned OFS_COEFF   = 0;
  localparam int unsigned OFS_DECIM   = 0;
  localparam int unsigned OFS_SHIFT   = 1;
  localparam int unsigned OFS_CLEAR   = 2;
  localparam int unsigned SHIFT_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } nyq_state_e;

  function automatic int unsigned acc_width(input int unsigned in_w,
                                            input int unsigned coeff_w,
                                            input int unsigned taps);
    return in_w + coeff_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/nyq_mac.sv
// Signed multiply-accumulate with synchronous clear (priority) and enable.
module nyq_mac #(
  parameter int unsigned A_WIDTH   = 24,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH = 45
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RBI,
  input  logic                        Clr_SI,
  input  logic                        En_SI,
  input  logic signed [A_WIDTH-1:0]   A_DI,
  input  logic signed [B_WIDTH-1:0]   B_DI,
  output logic signed [ACC_WIDTH-1:0] Acc_DO
);

  logic signed [A_WIDTH+B_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]       acc_q;

  assign prod   = A_DI * B_DI;
  assign Acc_DO = acc_q;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin : p_acc
    if (!Rst_RBI) begin
      acc_q <= '0;
    end else if (Clr_SI) begin
      acc_q <= '0;
    end else if (En_SI) begin
      acc_q <= acc_q + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/nyq_decim_fir.sv
// Decimating Nyquist FIR with one time-shared MAC and runtime decimation factor.
// Define NYQ_SAT_EN to saturate the output instead of wrapping it.
module nyq_decim_fir
  import nyq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned MEM_WIDTH   = 32,
  parameter int unsigned IN_WIDTH    = 24,
  parameter int unsigned OUT_WIDTH   = 24,
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned NUM_TAPS    = 32,
  parameter int unsigned MAX_DECIM   = 16
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  WrEn_SI,
  input  logic [ADDR_WIDTH-1:0] Addr_DI,
  input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
  input  logic [IN_WIDTH-1:0]   NYQ_In_DI,
  input  logic                  NYQ_InValid_SI,
  output logic                  NYQ_InRdy_DO,
  output logic [OUT_WIDTH-1:0]  NYQ_Out_DO,
  output logic                  NYQ_Valid_DO
);

  localparam int unsigned ACC_WIDTH = acc_width(IN_WIDTH, COEFF_WIDTH, NUM_TAPS);
  localparam int unsigned DW        = $clog2(MAX_DECIM + 1);
  localparam int unsigned TW        = $clog2(NUM_TAPS);

  nyq_state_e state_q, state_d;

  logic signed [COEFF_WIDTH-1:0] coef_q [NUM_TAPS];
  logic signed [IN_WIDTH-1:0]    x_q    [NUM_TAPS];
  logic [DW-1:0]                 decim_q, phase_q, decim_m1;
  logic [SHIFT_WIDTH-1:0]        shift_q;
  logic [TW-1:0]                 tap_q;
  logic signed [COEFF_WIDTH-1:0] coef_sel;
  logic signed [IN_WIDTH-1:0]    x_sel;
  logic signed [ACC_WIDTH-1:0]   acc, shifted;
  logic [OUT_WIDTH-1:0]          result, out_q;
  logic clr, wr_decim, wr_shift, decim_hit, last_tap;
  logic rdy, accept, mac_clr, mac_en, load_out, valid_q;

  assign clr      = WrEn_SI && (Addr_DI == ADDR_WIDTH'(NUM_TAPS + OFS_CLEAR));
  assign wr_decim = WrEn_SI && (Addr_DI == ADDR_WIDTH'(NUM_TAPS + OFS_DECIM));
  assign wr_shift = WrEn_SI && (Addr_DI == ADDR_WIDTH'(NUM_TAPS + OFS_SHIFT));
  // A stored D of 0 behaves as 1, so both decimate when phase >= 0.
  assign decim_m1  = (decim_q == '0) ? '0 : decim_q - DW'(1);
  assign decim_hit = (phase_q >= decim_m1);
  assign last_tap  = (tap_q == TW'(NUM_TAPS - 1));

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin : p_params
    if (!Rst_RBI) begin
      for (int k = 0; k < NUM_TAPS; k++) coef_q[k] <= '0;
      decim_q <= '0;
      shift_q <= '0;
    end else begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (WrEn_SI && (Addr_DI == ADDR_WIDTH'(OFS_COEFF + k)))
          coef_q[k] <= PAR_In_DI[COEFF_WIDTH-1:0];
      end
      // D is clamped on write; every later read sees the effective value.
      if (wr_decim)
        decim_q <= (PAR_In_DI > MEM_WIDTH'(MAX_DECIM)) ? DW'(MAX_DECIM) : PAR_In_DI[DW-1:0];
      if (wr_shift)
        shift_q <= PAR_In_DI[SHIFT_WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin : p_line
    if (!Rst_RBI) begin
      for (int k = 0; k < NUM_TAPS; k++) x_q[k] <= '0;
      phase_q <= '0;
    end else if (clr) begin
      for (int k = 0; k < NUM_TAPS; k++) x_q[k] <= '0;
      phase_q <= '0;
    end else if (accept) begin
      x_q[0] <= NYQ_In_DI;
      for (int k = 1; k < NUM_TAPS; k++) x_q[k] <= x_q[k-1];
      phase_q <= decim_hit ? '0 : phase_q + DW'(1);
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin : p_tap
    if (!Rst_RBI)    tap_q <= '0;
    else if (mac_clr) tap_q <= '0;
    else if (mac_en)  tap_q <= tap_q + TW'(1);
  end

  always_comb begin : p_tap_sel
    coef_sel = '0;
    x_sel    = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (tap_q == TW'(k)) begin
        coef_sel = coef_q[k];
        x_sel    = x_q[k];
      end
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin : p_state
    if (!Rst_RBI) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin : p_next
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && decim_hit) state_d = ST_MAC;
      ST_MAC:  if (last_tap) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clr) state_d = ST_IDLE;
  end

  always_comb begin : p_fsm_out
    rdy      = 1'b0;
    accept   = 1'b0;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    load_out = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        rdy     = 1'b1;
        accept  = NYQ_InValid_SI && !clr;
        mac_clr = accept && decim_hit;
      end
      ST_MAC:  mac_en   = !clr;
      ST_OUT:  load_out = !clr;
      default: ;
    endcase
  end

  nyq_mac #(
    .A_WIDTH  (IN_WIDTH),
    .B_WIDTH  (COEFF_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) i_mac (
    .Clk_CI (Clk_CI),
    .Rst_RBI(Rst_RBI),
    .Clr_SI (mac_clr),
    .En_SI  (mac_en),
    .A_DI   (x_sel),
    .B_DI   (coef_sel),
    .Acc_DO (acc)
  );

  assign shifted = acc >>> shift_q;

`ifdef NYQ_SAT_EN
  always_comb begin : p_reduce
    result = shifted[OUT_WIDTH-1:0];
    if (shifted[ACC_WIDTH-1:OUT_WIDTH-1] != {(ACC_WIDTH-OUT_WIDTH+1){shifted[ACC_WIDTH-1]}})
      result = shifted[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                    : {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end
`else
  logic unused_hi;
  assign unused_hi = ^shifted[ACC_WIDTH-1:OUT_WIDTH];
  assign result    = shifted[OUT_WIDTH-1:0];
`endif

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin : p_out
    if (!Rst_RBI) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= load_out;
      if (load_out) out_q <= result;
    end
  end

  assign NYQ_InRdy_DO = rdy;
  assign NYQ_Out_DO   = out_q;
  assign NYQ_Valid_DO = valid_q;

endmodule

// File: tb/tb_nyq_decim_fir.sv
// Scoreboard bench for nyq_decim_fir: a sample-history reference model
// predicts outputs and their timing; a monitor checks every DUT cycle.
module tb_nyq_decim_fir;

  localparam int NT  = 32;
  localparam int AW  = 9;
  localparam int LAT = NT + 1;

  logic          Clk_CI = 1'b0;
  logic          Rst_RBI = 1'b0;
  logic          WrEn_SI = 1'b0;
  logic [AW-1:0] Addr_DI = '0;
  logic [31:0]   PAR_In_DI = '0;
  logic [23:0]   NYQ_In_DI = '0;
  logic          NYQ_InValid_SI = 1'b0;
  logic          NYQ_InRdy_DO;
  logic [23:0]   NYQ_Out_DO;
  logic          NYQ_Valid_DO;

  nyq_decim_fir dut (
    .Clk_CI        (Clk_CI),
    .Rst_RBI       (Rst_RBI),
    .WrEn_SI       (WrEn_SI),
    .Addr_DI       (Addr_DI),
    .PAR_In_DI     (PAR_In_DI),
    .NYQ_In_DI     (NYQ_In_DI),
    .NYQ_InValid_SI(NYQ_InValid_SI),
    .NYQ_InRdy_DO  (NYQ_InRdy_DO),
    .NYQ_Out_DO    (NYQ_Out_DO),
    .NYQ_Valid_DO  (NYQ_Valid_DO)
  );

  always #5 Clk_CI = ~Clk_CI;

  typedef struct {
    logic [23:0] val;
    int          due;
  } exp_t;

  exp_t   expq[$];
  longint hist[$];
  longint cm[NT];
  int     dval = 0, sval = 0, phase = 0, busy_until = 0, cyc = 0;
  int     nchk = 0, npass = 0;

  always @(posedge Clk_CI) cyc++;

  function automatic void check(input string name, input longint act, input longint exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endfunction

  function automatic void model_reset();
    expq.delete();
    hist.delete();
    for (int k = 0; k < NT; k++) cm[k] = 0;
    dval = 0; sval = 0; phase = 0; busy_until = 0;
  endfunction

  // y = sum c[k]*x[k] over the accepted-sample history, newest first.
  function automatic void model_accept(input longint s, input int edge_c);
    int     deff;
    longint acc;
    longint sh;
    exp_t   e;
    hist.push_front(s);
    if (hist.size() > NT) void'(hist.pop_back());
    deff = (dval == 0) ? 1 : dval;
    if (phase >= deff - 1) begin
      phase = 0;
      acc = 0;
      for (int k = 0; k < hist.size(); k++) acc += cm[k] * hist[k];
      sh = acc >>> sval;
`ifdef NYQ_SAT_EN
      if (sh > 64'sd8388607) sh = 64'sd8388607;
      else if (sh < -64'sd8388608) sh = -64'sd8388608;
`endif
      e.val = sh[23:0];
      e.due = edge_c + LAT;
      busy_until = e.due;
      expq.push_back(e);
    end else begin
      phase++;
    end
  endfunction

  task automatic wr(input int addr, input longint data);
    logic signed [15:0] c16;
    Addr_DI   = AW'(addr);
    PAR_In_DI = data[31:0];
    WrEn_SI   = 1'b1;
    if (addr < NT) begin
      c16 = data[15:0];
      cm[addr] = c16;
    end else if (addr == NT) begin
      dval = (data > 16) ? 16 : int'(data);
    end else if (addr == NT + 1) begin
      sval = int'(data & 63);
    end else if (addr == NT + 2) begin
      hist.delete();
      phase = 0;
      if (expq.size() > 0 && expq[$].due >= cyc + 1) void'(expq.pop_back());
      if (busy_until > cyc + 1) busy_until = cyc + 1;
    end
    @(negedge Clk_CI);
    WrEn_SI = 1'b0;
  endtask

  task automatic send(input logic signed [23:0] s);
    int guard = 0;
    NYQ_In_DI      = s;
    NYQ_InValid_SI = 1'b1;
    while (!NYQ_InRdy_DO && guard < 2000) begin
      @(negedge Clk_CI);
      guard++;
    end
    if (guard >= 2000) begin
      check("send_timeout", 0, 1);
    end else begin
      model_accept(longint'(s), cyc + 1);
      @(negedge Clk_CI);
    end
    NYQ_InValid_SI = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((expq.size() != 0 || !NYQ_InRdy_DO) && guard < 200) begin
      @(negedge Clk_CI);
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 0, 1);
    repeat (2) @(negedge Clk_CI);
  endtask

  // Monitor: ready follows the model's busy window; each valid pops one expectation.
  always @(posedge Clk_CI) begin
    #1;
    check("ready", longint'(NYQ_InRdy_DO), longint'(cyc >= busy_until));
    if (NYQ_Valid_DO) begin
      if (expq.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("out_value", longint'(NYQ_Out_DO), longint'(e.val));
        check("out_latency", longint'(cyc), longint'(e.due));
      end
    end else if (expq.size() != 0 && cyc > expq[0].due) begin
      check("valid_late", 0, 1);
      void'(expq.pop_front());
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge Clk_CI);
    check("rst_out", longint'(NYQ_Out_DO), 0);
    check("rst_valid", longint'(NYQ_Valid_DO), 0);
    check("rst_ready", longint'(NYQ_InRdy_DO), 1);
    Rst_RBI = 1'b1;
    @(negedge Clk_CI);

    // Impulse response, D=1
    for (int k = 0; k < NT; k++) wr(k, k + 1);
    wr(NT, 1);
    wr(NT + 1, 0);
    send(24'sd1);
    repeat (NT - 1) send(24'sd0);
    drain();

    // D=4 ramp on constant input
    wr(NT + 2, 0);
    for (int k = 0; k < NT; k++) wr(k, 1);
    wr(NT, 4);
    repeat (48) send(24'sd100);
    drain();

    // Overflow
    wr(NT + 2, 0);
    for (int k = 0; k < NT; k++) wr(k, 32'h7FFF);
    wr(NT, 1);
    repeat (NT) send(24'sh7FFFFF);
    drain();

    // Shift: 256*3 >>> 8
    wr(NT + 2, 0);
    for (int k = 0; k < NT; k++) wr(k, (k == 0) ? 3 : 0);
    wr(NT + 1, 8);
    send(24'sd256);
    drain();

    // Randomized rounds, including out-of-range D
    for (int r = 0; r < 4; r++) begin
      wr(NT + 2, 0);
      for (int k = 0; k < NT; k++) wr(k, longint'($urandom()));
      wr(NT, $urandom_range(0, 20));
      wr(NT + 1, $urandom_range(0, 24));
      repeat (30) send(24'($urandom()));
      drain();
    end

    // Soft clear mid-MAC, then a clean impulse
    for (int k = 0; k < NT; k++) wr(k, k + 1);
    wr(NT, 1);
    wr(NT + 1, 0);
    send(24'sd5);
    repeat (10) @(negedge Clk_CI);
    wr(NT + 2, 32'hDEAD);
    check("ready_after_clear", longint'(NYQ_InRdy_DO), 1);
    send(24'sd1);
    send(24'sd0);
    send(24'sd0);
    drain();

    // Reset pulse mid-MAC
    send(24'sd7);
    repeat (5) @(negedge Clk_CI);
    Rst_RBI = 1'b0;
    model_reset();
    @(negedge Clk_CI);
    check("midrst_out", longint'(NYQ_Out_DO), 0);
    check("midrst_valid", longint'(NYQ_Valid_DO), 0);
    check("midrst_ready", longint'(NYQ_InRdy_DO), 1);
    Rst_RBI = 1'b1;
    @(negedge Clk_CI);
    send(24'sd12345);
    drain();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/nyq_decim_fir.md
# nyq_decim_fir

Parametrised decimating Nyquist FIR filter for the SynTech receive chain: a programmable low-pass that decimates by a runtime-selected factor. It accepts samples through a valid/ready handshake and keeps coefficients and control in the standard block parameter memory. It computes one output per D accepted inputs with a single time-shared multiply-accumulate, replacing the fixed 4-MAC, decimate-by-8 Nyquist block.

## Interface
- ADDR_WIDTH, 9, parameter memory address width
- MEM_WIDTH, 32, parameter word width
- IN_WIDTH, 24, input sample width (signed)
- OUT_WIDTH, 24, output sample width (signed)
- COEFF_WIDTH, 16, coefficient width (signed, low bits of a parameter word)
- NUM_TAPS, 32, filter length; 2..(2^ADDR_WIDTH − 3)
- MAX_DECIM, 16, largest decimation factor

- Clk_CI  in  1  clock
- Rst_RBI  in  1  reset, asynchronous, active-low
- WrEn_SI  in  1  parameter write enable, active high
- Addr_DI  in  ADDR_WIDTH  parameter address
- PAR_In_DI  in  MEM_WIDTH  parameter write data
- NYQ_In_DI  in  IN_WIDTH  input sample, signed
- NYQ_InValid_SI  in  1  input sample valid
- NYQ_InRdy_DO  out  1  block can accept a sample
- NYQ_Out_DO  out  OUT_WIDTH  filtered, decimated sample, signed
- NYQ_Valid_DO  out  1  one-cycle strobe, NYQ_Out_DO updated

## Operation
- Address map:
  - 0..NUM_TAPS−1: coefficient c[k].
  - NUM_TAPS: decimation factor D. 0 acts as 1; values above MAX_DECIM act as MAX_DECIM.
  - NUM_TAPS+1: output shift S, bits [5:0].
  - NUM_TAPS+2: soft clear. A write strobe with any data triggers it; the word is not stored.
- Reset: all parameters 0, delay line 0, phase 0, state IDLE.
- A sample is accepted on an edge with NYQ_InValid_SI && NYQ_InRdy_DO. It shifts into delay line x[0]; older samples move to x[k+1].
- The phase counter increments on each accepted sample. When phase ≥ D−1 at acceptance, phase goes to 0 and a computation starts.
- y = Σ c[k]·x[k], k = 0..NUM_TAPS−1.
- Accumulator is signed, IN_WIDTH+COEFF_WIDTH+clog2(NUM_TAPS) bits. Products are full precision; there is no intermediate overflow.
- Result = acc >>> S (arithmetic), then reduced to OUT_WIDTH (see Configuration).
- FSM:
  - IDLE: ready=1. A decimating acceptance goes to MAC.
  - MAC: NUM_TAPS cycles. Accumulator is cleared on entry, one tap per cycle, tap index 0 first. Then goes to OUT.
  - OUT: one cycle. Loads output register, pulses valid, returns to IDLE.
- Coefficient, D and S reads are live. A write during MAC affects taps not yet read; an S write affects the pending OUT.
- Lowering D below current phase+1: the next accepted sample decimates.
- Soft clear: zeroes delay line and phase, and aborts MAC/OUT to IDLE with no valid. NYQ_Out_DO holds its value. A sample offered in the same cycle is dropped.

## Timing
- NYQ_InRdy_DO = (state == IDLE), combinational from the state register. It is low from the edge after a decimating acceptance until OUT returns to IDLE.
- A non-decimating acceptance keeps ready high, so back-to-back samples are allowed.
- Latency: decimating acceptance at edge n → NYQ_Out_DO and NYQ_Valid_DO updated at edge n+NUM_TAPS+1. Valid is high for exactly one cycle.
- Minimum output spacing is NUM_TAPS+1 cycles. Sustained throughput with D=1 is one sample per NUM_TAPS+1 cycles.
- Output reset values: NYQ_Out_DO=0, NYQ_Valid_DO=0, NYQ_InRdy_DO=1.
- Rst_RBI asserted mid-MAC clears everything immediately; there is no output strobe.
- Simultaneous events:
  - Parameter write and sample acceptance: both take effect.
  - Soft clear and acceptance: clear wins.

## Configuration
- NYQ_SAT_EN defined: the shifted result saturates to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
- NYQ_SAT_EN undefined: the shifted result is truncated to its low OUT_WIDTH bits (two's-complement wrap).

## Structure
- Package nyq_pkg contains:
  - address-map offset constants (coefficient base, D, S, clear);
  - the FSM state enum (IDLE, MAC, OUT);
  - an accumulator-width function.
- Sub-module nyq_mac: signed multiply-accumulate with synchronous clear and enable, widths as parameters.
- Delay line, phase counter, FSM and output stage live in nyq_decim_fir.

## Test plan
- Impulse, NUM_TAPS=32, D=1, S=0, c[k]=k+1, input 1 then zeros → 32 consecutive outputs 1,2,…,32. Each valid arrives 33 cycles after its acceptance.
- D=4, all c=1, S=0, constant input 100 streamed at max rate → 7 outputs ramp (400, 800, …), then a steady 3200 once the line is full. One valid per 4 accepted samples; ready low for 33 cycles after each 4th sample.
- Overflow, c all 0x7FFF, input 0x7FFFFF, S=0 → with NYQ_SAT_EN, output 0x7FFFFF; without it, output equals low 24 bits of the exact sum.
- S=8, single sample 256 with c[0]=3 → output 3.
- Soft clear written mid-MAC → no valid strobe, ready=1 next cycle. A subsequent impulse reproduces the clean response with no stale samples.
- Rst_RBI pulsed low during MAC → outputs 0, ready 1, all parameters 0. The next computation yields 0.
